// File: rtl/fir_sample_feeder_pkg.sv
// Shared constants and frame-state encoding for the FIR sample feeder and its
// 128-tap serial filter.
package fir_sample_feeder_pkg;

  localparam int FIR_WIDTH  = 18;
  localparam int FIR_TAPS   = 128;
  localparam int PHASE_LOAD = FIR_TAPS - 1;

  typedef enum logic [1:0] {
    FR_IDLE = 2'd0,
    FR_RUN  = 2'd1,
    FR_LOAD = 2'd2
  } frame_t;

endpackage

// File: rtl/fir_sample_feeder_fifo.sv
// Small first-word-fall-through sample FIFO; an extra pointer bit separates
// full from empty when the pointers alias.
module sample_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic signed [WIDTH-1:0]  din,
  input  logic                     pop,
  output logic signed [WIDTH-1:0]  dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic                    do_push;
  logic                    do_pop;

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds buffered samples to the serial FIR in lock-step with its tap counter,
// stalls it when starved, and re-times its result into a valid strobe.
module fir_sample_feeder
  import fir_sample_feeder_pkg::*;
#(
  parameter int WIDTH = FIR_WIDTH,
  parameter int TAPS  = FIR_TAPS,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [WIDTH-1:0]  in_sample,
  input  logic                     in_valid,
  output logic signed [WIDTH-1:0]  fir_sig,
  output logic                     fir_ready,
  input  logic signed [WIDTH-1:0]  fir_result,
  output logic signed [WIDTH-1:0]  out_sample,
  output logic                     out_valid,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int            PW         = $clog2(TAPS);
  localparam logic [PW-1:0] PHASE_LAST = PW'(TAPS - 1);

  logic [PW-1:0]           phase_n;
  logic [PW-1:0]           phase;
  logic signed [WIDTH-1:0] head;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    drop;
  frame_t                  frame;
  logic                    primed;
  logic                    load_d;
  logic                    primed_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // The phase is held inverted so an all-zero power-up register reads as
  // TAPS-1, the filter's own power-up index. Reset never touches it.
  assign phase = ~phase_n;

  always_ff @(posedge clk) begin
    if (fir_ready) phase_n <= phase_n - 1'b1;
  end

  // While reset is held the FIFO counts as empty, so an in-flight frame runs
  // out and the filter parks at its load index.
  always_comb begin
    frame = FR_RUN;
    if (phase == PHASE_LAST) frame = (!empty && !rst) ? FR_LOAD : FR_IDLE;
  end

  assign fir_ready = (frame != FR_IDLE);
  assign fir_sig   = (frame == FR_LOAD) ? head : '0;
  assign pop       = (frame == FR_LOAD);
  assign push      = in_valid && !rst && (!full || pop);
  assign drop      = in_valid && !rst && full && !pop;

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_sample),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      primed     <= 1'b0;
      load_d     <= 1'b0;
      primed_p0  <= 1'b0;
      out_valid  <= 1'b0;
      out_sample <= '0;
    end else begin
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
      if (pop) primed <= 1'b1;
      // p0: cycle after LOAD; primed_p0 remembers whether the finished frame held data
      load_d    <= pop;
      primed_p0 <= primed;
      // p1: filter result captured one cycle after load_d
      out_valid <= load_d && primed_p0;
      if (load_d && primed_p0) out_sample <= fir_result;
    end
  end

endmodule

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
Upstream companion to the 128-tap serial FIR filter. The filter consumes one sample per 128 enabled clocks and latches its input only on the load cycle of its internal tap counter.
This block buffers samples arriving on an irregular strobe in a small FIFO and drives the filter's input sample and ready enable in lock-step with that counter. It stalls the filter cleanly when no sample is waiting, and re-times the filter result into a valid-strobed output for downstream logic.

Parameters:
WIDTH, 18, sample width in bits (signed), matching the filter.
TAPS, 128, clocks per filter frame; power of 2; phase counter width PW = log2(TAPS).
DEPTH, 4, FIFO depth in samples; power of 2, at least 2.
CNT_W, 8, width of the saturating drop counter.

Ports:
clk  in  1  single system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
in_sample  in  WIDTH  signed sample from the ADC side.
in_valid  in  1  one-cycle strobe; in_sample is valid in that cycle. There is no backpressure.
fir_sig  out  WIDTH  to the filter's input_sig.
fir_ready  out  1  to the filter's ready (clock enable).
fir_result  in  WIDTH  from the filter's filtred_sig.
out_sample  out  WIDTH  registered filter result.
out_valid  out  1  one-cycle strobe qualifying out_sample.
overflow  out  1  sticky flag: at least one sample was dropped since reset.
drop_count  out  CNT_W  saturating count of dropped samples.
fifo_level  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Phase counter (PW bits)
  - Mirrors the filter's read index. Initial value TAPS-1; this matches the filter's power-up value.
  - Increments, with wrap, on every cycle where fir_ready=1.
  - rst does NOT clear it. The filter has no reset, so the counter must stay aligned with it.
- Frame states, derived from phase and FIFO status:
  - RUN: phase != TAPS-1. fir_ready=1, fir_sig=0.
  - LOAD: phase == TAPS-1 and FIFO not empty. fir_ready=1, fir_sig = FIFO head (combinational), pop in the same cycle.
  - IDLE: phase == TAPS-1 and FIFO empty. fir_ready=0, fir_sig=0. The filter is frozen.
- fir_ready and fir_sig are combinational from the registered phase and FIFO state. No latency between FIFO head and fir_sig.
- FIFO push and drop rules:
  - in_valid while not full: push.
  - in_valid while full with a pop in the same cycle: push is accepted and level is unchanged.
  - in_valid while full without a pop: sample dropped, overflow <= 1, drop_count increments and saturates at 2^CNT_W-1.
- Result path: a registered flag load_d marks the cycle after a LOAD.
  - The filter result is valid from that cycle onward.
  - The cycle after load_d: out_sample <= fir_result and out_valid <= 1 for exactly one cycle.
  - Total latency from the LOAD cycle to out_valid is 2 cycles. This result corresponds to the frame that finished before that load.
- Priming: the first LOAD after rst produces no out_valid, because the prior frame held no valid data. A primed flag sets on the first LOAD.
- Reset (synchronous, while rst=1 at posedge):
  - FIFO flushed (fifo_level=0).
  - overflow=0, drop_count=0, out_valid=0, out_sample=0, primed=0, load_d=0.
  - In-flight frame: if phase != TAPS-1, the block keeps driving RUN (fir_ready=1, fir_sig=0) until the phase reaches TAPS-1, then sits in IDLE. This keeps the filter aligned.
  - in_valid is ignored during the rst cycle.
- Simultaneous events: LOAD pop and in_valid push in the same cycle are both honoured.
- Wrap-around: the phase counter and the FIFO pointers wrap naturally. The FIFO full/empty decision uses an extra pointer bit.

Decomposition:
- Shared package/header holds: WIDTH default (18), TAPS default (128), and localparam PHASE_LOAD = TAPS-1. The filter uses the same values.
- One sub-module, sample_fifo: a synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: clk, rst, push, din, pop, dout (first-word fall-through), full, empty, level.
- The feeder top contains the phase counter, frame decode, drop accounting and result re-timing.

Test Plan:
- Power-up, no input: fir_ready=0 indefinitely, out_valid never asserts, fifo_level=0.
- Single sample 18'sd1000 at cycle 10:
  - Expected sequence: LOAD at cycle 10 or 11 with fir_sig=1000, then exactly 127 RUN cycles, then IDLE.
  - No out_valid (priming).
  - A second sample then produces out_valid 2 cycles after its LOAD.
- Impulse through the real filter (sample 65535, then zeros every 130 cycles): successive out_sample values follow the scaled coefficients 1, 3, 3, 1, -2, -7, ... within ±1.
- Burst of 6 in_valid on back-to-back cycles, DEPTH=4:
  - 1 is popped by LOAD, 4 are buffered, 1 is dropped.
  - Expected: overflow=1, drop_count=1, fifo_level=4.
- rst asserted at phase 40: fir_ready stays 1 for 87 more cycles, then 0. FIFO is empty and drop_count=0 after reset.
- Push while full coincident with LOAD pop: no drop, fifo_level stays DEPTH.
